// File: rtl/hp_burst_master.sv
// AXI3 burst master for the Zynq HP ports: one read or write burst (1-16 beats)
// at a time, stream-side data ports and one status record per command.
module hp_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter bit CHECK_4K   = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    // command
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [31:0]           i_cmd_addr,
    input  logic [3:0]            i_cmd_len,
    input  logic [5:0]            i_cmd_id,
    input  logic [3:0]            i_cfg_cache,
    input  logic [2:0]            i_cfg_prot,
    // write-data stream
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    // read-data stream
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_last,
    // status stream
    output logic                  o_st_valid,
    input  logic                  i_st_ready,
    output logic                  o_st_write,
    output logic [5:0]            o_st_id,
    output logic [1:0]            o_st_resp,
    output logic [1:0]            o_st_err,
    // AXI3 read address
    output logic [31:0]           o_araddr,
    output logic [3:0]            o_arlen,
    output logic [2:0]            o_arsize,
    output logic [1:0]            o_arburst,
    output logic [1:0]            o_arlock,
    output logic [3:0]            o_arcache,
    output logic [2:0]            o_arprot,
    output logic [3:0]            o_arqos,
    output logic [5:0]            o_arid,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    // AXI3 write address
    output logic [31:0]           o_awaddr,
    output logic [3:0]            o_awlen,
    output logic [2:0]            o_awsize,
    output logic [1:0]            o_awburst,
    output logic [1:0]            o_awlock,
    output logic [3:0]            o_awcache,
    output logic [2:0]            o_awprot,
    output logic [3:0]            o_awqos,
    output logic [5:0]            o_awid,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    // AXI3 write data
    output logic [5:0]            o_wid,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    // AXI3 write response
    input  logic [5:0]            i_bid,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    // AXI3 read data
    input  logic [5:0]            i_rid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rlast,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    // state   | meaning
    // IDLE    | cmd_ready high, waiting for a command
    // ADDR    | ar/awvalid held until the slave accepts the address
    // WDATA   | write beats passed through from the wr stream
    // WRESP   | bready high, waiting for the write response
    // RDATA   | read beats passed through to the rd stream
    // STATUS  | completion record held until st_ready
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRESP,
        S_RDATA,
        S_STATUS
    } state_t;

    localparam int SIZE = $clog2(STRB_WIDTH);

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_awvalid;
    logic        r_arvalid;
    logic        r_bready;
    logic        r_st_valid;
    logic        r_write;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [5:0]  r_id;
    logic [3:0]  r_cnt;
    logic [1:0]  r_resp;
    logic [1:0]  r_err;

    logic [31:0] w_cmd_addr;
    logic [12:0] w_span;
    logic [12:0] w_end;
    logic        w_cross;
    logic        w_at_len;
    logic        w_in_wdata;
    logic        w_in_rdata;
    logic        w_unused;

    assign w_cmd_addr = {i_cmd_addr[31:SIZE], {SIZE{1'b0}}};
    assign w_span     = (13'(i_cmd_len) + 13'd1) << SIZE;
    assign w_end      = {1'b0, w_cmd_addr[11:0]} + w_span;
    assign w_cross    = CHECK_4K && (w_end > 13'd4096);
    assign w_at_len   = (r_cnt == r_len);
    assign w_in_wdata = (r_state == S_WDATA);
    assign w_in_rdata = (r_state == S_RDATA);
    assign w_unused   = &{1'b0, i_rid, i_cmd_addr[SIZE-1:0]};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_st_valid  <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_resp      <= '0;
            r_err       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= i_cmd_write;
                        r_addr      <= w_cmd_addr;
                        r_len       <= i_cmd_len;
                        r_id        <= i_cmd_id;
                        r_cnt       <= '0;
                        // a 4 KB crossing is reported without touching the bus
                        if (w_cross) begin
                            r_resp     <= 2'b10;
                            r_err      <= 2'b10;
                            r_st_valid <= 1'b1;
                            r_state    <= S_STATUS;
                        end else begin
                            r_resp    <= 2'b00;
                            r_err     <= 2'b00;
                            r_awvalid <= i_cmd_write;
                            r_arvalid <= !i_cmd_write;
                            r_state   <= S_ADDR;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (r_awvalid && i_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= S_WDATA;
                    end else if (r_arvalid && i_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (i_wr_valid && i_wready) begin
                        if (w_at_len) begin
                            r_cnt    <= '0;
                            r_bready <= 1'b1;
                            r_state  <= S_WRESP;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_WRESP: begin
                    if (i_bvalid) begin
                        r_resp <= i_bresp;
                        if (i_bid != r_id)
                            r_err[0] <= 1'b1;
                        r_bready   <= 1'b0;
                        r_st_valid <= 1'b1;
                        r_state    <= S_STATUS;
                    end
                end
                S_RDATA: begin
                    if (i_rvalid && i_rd_ready) begin
                        if (i_rresp > r_resp)
                            r_resp <= i_rresp;
                        // the beat count, not rlast, decides where the burst ends
                        if (i_rlast != w_at_len)
                            r_err[0] <= 1'b1;
                        if (w_at_len) begin
                            r_cnt      <= '0;
                            r_st_valid <= 1'b1;
                            r_state    <= S_STATUS;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_STATUS: begin
                    if (i_st_ready) begin
                        r_st_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;

    assign o_araddr  = r_addr;
    assign o_arlen   = r_len;
    assign o_arsize  = 3'(SIZE);
    assign o_arburst = 2'b01;
    assign o_arlock  = 2'b00;
    assign o_arcache = i_cfg_cache;
    assign o_arprot  = i_cfg_prot;
    assign o_arqos   = 4'b0000;
    assign o_arid    = r_id;
    assign o_arvalid = r_arvalid;

    assign o_awaddr  = r_addr;
    assign o_awlen   = r_len;
    assign o_awsize  = 3'(SIZE);
    assign o_awburst = 2'b01;
    assign o_awlock  = 2'b00;
    assign o_awcache = i_cfg_cache;
    assign o_awprot  = i_cfg_prot;
    assign o_awqos   = 4'b0000;
    assign o_awid    = r_id;
    assign o_awvalid = r_awvalid;

    assign o_wid      = r_id;
    assign o_wdata    = w_in_wdata ? i_wr_data : '0;
    assign o_wstrb    = '1;
    assign o_wlast    = w_in_wdata && w_at_len;
    assign o_wvalid   = w_in_wdata && i_wr_valid;
    assign o_wr_ready = w_in_wdata && i_wready;

    assign o_bready = r_bready;

    assign o_rd_valid = w_in_rdata && i_rvalid;
    assign o_rd_data  = w_in_rdata ? i_rdata : '0;
    assign o_rd_last  = w_in_rdata && w_at_len;
    assign o_rready   = w_in_rdata && i_rd_ready;

    assign o_st_valid = r_st_valid;
    assign o_st_write = r_write;
    assign o_st_id    = r_id;
    assign o_st_resp  = r_resp;
    assign o_st_err   = r_err;

endmodule

// File: tb/tb_hp_burst_master.sv
// Directed bench for hp_burst_master: 32-bit instance for most scenarios,
// 64-bit instance for the wide single-beat write.
module tb_hp_burst_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit instance
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [5:0]  cmd_id;
    logic [3:0]  cfg_cache;
    logic [2:0]  cfg_prot;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
    logic [31:0] wr_data, rd_data;
    logic        st_valid, st_ready, st_write;
    logic [5:0]  st_id;
    logic [1:0]  st_resp, st_err;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arlen, awlen, arcache, awcache, arqos, awqos;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic [5:0]  arid, awid, wid, bid, rid;
    logic        arvalid, arready, awvalid, awready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, rlast, rvalid, rready;

    hp_burst_master #(.DATA_WIDTH(32), .CHECK_4K(1'b1)) u_dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_id(cmd_id),
        .i_cfg_cache(cfg_cache), .i_cfg_prot(cfg_prot),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_st_valid(st_valid), .i_st_ready(st_ready), .o_st_write(st_write),
        .o_st_id(st_id), .o_st_resp(st_resp), .o_st_err(st_err),
        .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
        .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot), .o_arqos(arqos),
        .o_arid(arid), .o_arvalid(arvalid), .i_arready(arready),
        .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
        .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot), .o_awqos(awqos),
        .o_awid(awid), .o_awvalid(awvalid), .i_awready(awready),
        .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
        .o_wvalid(wvalid), .i_wready(wready),
        .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
        .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
        .i_rvalid(rvalid), .o_rready(rready)
    );

    // 64-bit instance
    logic        cmd_valid_b, cmd_ready_b;
    logic [31:0] cmd_addr_b;
    logic [5:0]  cmd_id_b;
    logic        wr_valid_b, wr_ready_b, rd_valid_b, rd_last_b;
    logic [63:0] wr_data_b, rd_data_b;
    logic        st_valid_b, st_ready_b, st_write_b;
    logic [5:0]  st_id_b;
    logic [1:0]  st_resp_b, st_err_b;
    logic [31:0] araddr_b, awaddr_b;
    logic [3:0]  arlen_b, awlen_b, arcache_b, awcache_b, arqos_b, awqos_b;
    logic [2:0]  arsize_b, awsize_b, arprot_b, awprot_b;
    logic [1:0]  arburst_b, awburst_b, arlock_b, awlock_b;
    logic [5:0]  arid_b, awid_b, wid_b, bid_b;
    logic        arvalid_b, awvalid_b, awready_b;
    logic [63:0] wdata_b;
    logic [7:0]  wstrb_b;
    logic        wlast_b, wvalid_b, wready_b, bvalid_b, bready_b, rready_b;

    hp_burst_master #(.DATA_WIDTH(64), .CHECK_4K(1'b1)) u_dut64 (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid_b), .o_cmd_ready(cmd_ready_b), .i_cmd_write(1'b1),
        .i_cmd_addr(cmd_addr_b), .i_cmd_len(4'd0), .i_cmd_id(cmd_id_b),
        .i_cfg_cache(cfg_cache), .i_cfg_prot(cfg_prot),
        .i_wr_valid(wr_valid_b), .o_wr_ready(wr_ready_b), .i_wr_data(wr_data_b),
        .o_rd_valid(rd_valid_b), .i_rd_ready(1'b0), .o_rd_data(rd_data_b), .o_rd_last(rd_last_b),
        .o_st_valid(st_valid_b), .i_st_ready(st_ready_b), .o_st_write(st_write_b),
        .o_st_id(st_id_b), .o_st_resp(st_resp_b), .o_st_err(st_err_b),
        .o_araddr(araddr_b), .o_arlen(arlen_b), .o_arsize(arsize_b), .o_arburst(arburst_b),
        .o_arlock(arlock_b), .o_arcache(arcache_b), .o_arprot(arprot_b), .o_arqos(arqos_b),
        .o_arid(arid_b), .o_arvalid(arvalid_b), .i_arready(1'b0),
        .o_awaddr(awaddr_b), .o_awlen(awlen_b), .o_awsize(awsize_b), .o_awburst(awburst_b),
        .o_awlock(awlock_b), .o_awcache(awcache_b), .o_awprot(awprot_b), .o_awqos(awqos_b),
        .o_awid(awid_b), .o_awvalid(awvalid_b), .i_awready(awready_b),
        .o_wid(wid_b), .o_wdata(wdata_b), .o_wstrb(wstrb_b), .o_wlast(wlast_b),
        .o_wvalid(wvalid_b), .i_wready(wready_b),
        .i_bid(bid_b), .i_bresp(2'b00), .i_bvalid(bvalid_b), .o_bready(bready_b),
        .i_rid(6'd0), .i_rdata(64'd0), .i_rresp(2'b00), .i_rlast(1'b0),
        .i_rvalid(1'b0), .o_rready(rready_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [3:0] l,
                            input logic [5:0] id);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
        #1;
        while (!cmd_ready && n < 30) begin @(negedge clk); #1; n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1 within 30 cycles", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_status(output logic w, output logic [5:0] id,
                               output logic [1:0] resp, output logic [1:0] err);
        int n = 0;
        st_ready = 1'b1;
        #1;
        while (!st_valid && n < 30) begin @(negedge clk); #1; n++; end
        checks++;
        if (st_valid !== 1'b1) begin
            errors++; $display("FAIL st_timeout: st_valid=%b required 1", st_valid);
        end
        w = st_write; id = st_id; resp = st_resp; err = st_err;
        @(negedge clk);
        st_ready = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || st_valid !== 1'b0) begin
            errors++; $display("FAIL st_release: cmd_ready=%b st_valid=%b required 0 0", cmd_ready, st_valid);
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                               input int aw_delay, input logic [1:0] bresp_v, input logic [5:0] bid_v);
        int beat = 0, aw_cnt = 0, wl_cnt = 0, overlap = 0, n = 0;
        send_cmd(1'b1, addr, len, id);
        wready = 1'b1;
        for (int cyc = 0; cyc < 80 && beat <= int'(len); cyc++) begin
            awready  = (cyc >= aw_delay);
            wr_valid = 1'b1;
            wr_data  = 32'hA0 + beat;
            #1;
            if (wvalid && awvalid) overlap++;
            if (awvalid && awready) begin
                aw_cnt++; checks++;
                if (awaddr !== {addr[31:2], 2'b00} || awlen !== len || awsize !== 3'd2 ||
                    awid !== id || awburst !== 2'b01 || awcache !== cfg_cache) begin
                    errors++;
                    $display("FAIL aw_fields: addr=%h len=%0d size=%0d id=%0d burst=%0d required addr=%h len=%0d size=2 id=%0d burst=1",
                             awaddr, awlen, awsize, awid, awburst, {addr[31:2], 2'b00}, len, id);
                end
            end
            if (wvalid && wready) begin
                checks++;
                if (wdata !== 32'hA0 + beat || wlast !== (beat == int'(len)) || wstrb !== 4'hF ||
                    wid !== id || wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL w_beat%0d: wdata=%h wlast=%b wstrb=%h wid=%0d wr_ready=%b required %h %b f %0d 1",
                             beat, wdata, wlast, wstrb, wid, wr_ready, 32'hA0 + beat, beat == int'(len), id);
                end
                if (wlast) wl_cnt++;
                beat++;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0; awready = 1'b0;
        checks++;
        if (aw_cnt != 1 || beat != int'(len) + 1 || wl_cnt != 1 || overlap != 0) begin
            errors++;
            $display("FAIL w_counts: aw=%0d beats=%0d wlast=%0d overlap=%0d required 1 %0d 1 0",
                     aw_cnt, beat, wl_cnt, overlap, int'(len) + 1);
        end
        bvalid = 1'b1; bresp = bresp_v; bid = bid_v;
        #1;
        while (!bready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (bready !== 1'b1) begin
            errors++; $display("FAIL bready: bready=%b required 1", bready);
        end
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                              input bit toggle, input int rlast_beat, input int err_beat);
        int k = 0, ar_cnt = 0, rl_cnt = 0;
        bit ar_done = 1'b0;
        send_cmd(1'b0, addr, len, id);
        for (int cyc = 0; cyc < 150 && k <= int'(len); cyc++) begin
            arready  = 1'b1;
            rvalid   = ar_done;
            rdata    = 32'hB00 + k;
            rresp    = (k == err_beat) ? 2'b10 : 2'b00;
            rlast    = (k == rlast_beat);
            rid      = id;
            rd_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (arvalid && arready) begin
                ar_cnt++; checks++;
                if (araddr !== {addr[31:2], 2'b00} || arlen !== len || arsize !== 3'd2 ||
                    arid !== id || arburst !== 2'b01 || arprot !== cfg_prot) begin
                    errors++;
                    $display("FAIL ar_fields: addr=%h len=%0d size=%0d id=%0d required addr=%h len=%0d size=2 id=%0d",
                             araddr, arlen, arsize, arid, {addr[31:2], 2'b00}, len, id);
                end
                ar_done = 1'b1;
            end
            if (rvalid && rready) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 32'hB00 + k || rd_last !== (k == int'(len))) begin
                    errors++;
                    $display("FAIL r_beat%0d: rd_valid=%b rd_data=%h rd_last=%b required 1 %h %b",
                             k, rd_valid, rd_data, rd_last, 32'hB00 + k, k == int'(len));
                end
                if (rd_last) rl_cnt++;
                k++;
            end
            @(negedge clk);
        end
        rvalid = 1'b0; arready = 1'b0; rd_ready = 1'b0;
        checks++;
        if (ar_cnt != 1 || k != int'(len) + 1 || rl_cnt != 1) begin
            errors++;
            $display("FAIL r_counts: ar=%0d beats=%0d rd_last=%0d required 1 %0d 1", ar_cnt, k, rl_cnt, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            bready !== 1'b0 || rready !== 1'b0 || st_valid !== 1'b0 || rd_data !== 32'd0 ||
            st_id !== 6'd0 || st_resp !== 2'd0 || st_err !== 2'd0 || cmd_ready_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: cmd_ready=%b arvalid=%b awvalid=%b st_valid=%b rd_data=%h required all 0",
                     cmd_ready, arvalid, awvalid, st_valid, rd_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || cmd_ready_b !== 1'b1) begin
            errors++; $display("FAIL reset_release: cmd_ready=%b/%b required 1/1", cmd_ready, cmd_ready_b);
        end
    endtask

    task automatic test_write_basic();
        logic w; logic [5:0] id; logic [1:0] resp, err;
        write_burst(32'h1000_0000, 4'd3, 6'd5, 2, 2'b00, 6'd5);
        wait_status(w, id, resp, err);
        checks++;
        if (w !== 1'b1 || id !== 6'd5 || resp !== 2'b00 || err !== 2'b00) begin
            errors++; $display("FAIL write_status: w=%b id=%0d resp=%0d err=%0d required 1 5 0 0", w, id, resp, err);
        end
    endtask

    task automatic test_write_bid_mismatch();
        logic w; logic [5:0] id; logic [1:0] resp, err;
        write_burst(32'h0000_0104, 4'd0, 6'd7, 0, 2'b01, 6'd8);
        wait_status(w, id, resp, err);
        checks++;
        if (w !== 1'b1 || id !== 6'd7 || resp !== 2'b01 || err !== 2'b01) begin
            errors++; $display("FAIL bid_status: w=%b id=%0d resp=%0d err=%0d required 1 7 1 1", w, id, resp, err);
        end
    endtask

    task automatic test_read_len15();
        logic w; logic [5:0] id; logic [1:0] resp, err;
        read_burst(32'h2000_0103, 4'd15, 6'd21, 1'b1, 15, 7);
        wait_status(w, id, resp, err);
        checks++;
        if (w !== 1'b0 || id !== 6'd21 || resp !== 2'b10 || err !== 2'b00) begin
            errors++; $display("FAIL read15_status: w=%b id=%0d resp=%0d err=%0d required 0 21 2 0", w, id, resp, err);
        end
    endtask

    task automatic test_read_rlast_mismatch();
        logic w; logic [5:0] id; logic [1:0] resp, err;
        read_burst(32'h3000_0040, 4'd1, 6'd33, 1'b0, 0, -1);
        wait_status(w, id, resp, err);
        checks++;
        if (w !== 1'b0 || id !== 6'd33 || resp !== 2'b00 || err !== 2'b01) begin
            errors++; $display("FAIL rlast_status: w=%b id=%0d resp=%0d err=%0d required 0 33 0 1", w, id, resp, err);
        end
        read_burst(32'h3000_0080, 4'd0, 6'd34, 1'b0, 0, -1);
        wait_status(w, id, resp, err);
        checks++;
        if (resp !== 2'b00 || err !== 2'b00 || id !== 6'd34) begin
            errors++; $display("FAIL read0_status: id=%0d resp=%0d err=%0d required 34 0 0", id, resp, err);
        end
    endtask

    task automatic test_4k();
        logic w; logic [5:0] id; logic [1:0] resp, err;
        int addr_seen = 0;
        send_cmd(1'b0, 32'h0000_0FF8, 4'd3, 6'd12);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (arvalid || awvalid) addr_seen++;
            @(negedge clk);
        end
        checks++;
        if (addr_seen != 0) begin
            errors++; $display("FAIL 4k_no_addr: address valid cycles=%0d required 0", addr_seen);
        end
        wait_status(w, id, resp, err);
        checks++;
        if (w !== 1'b0 || id !== 6'd12 || resp !== 2'b10 || err !== 2'b10) begin
            errors++; $display("FAIL 4k_status: w=%b id=%0d resp=%0d err=%0d required 0 12 2 2", w, id, resp, err);
        end
        // ending exactly on the boundary is legal
        read_burst(32'h0000_0FF0, 4'd3, 6'd13, 1'b0, 3, -1);
        wait_status(w, id, resp, err);
        checks++;
        if (resp !== 2'b00 || err !== 2'b00 || id !== 6'd13) begin
            errors++; $display("FAIL 4k_edge_status: id=%0d resp=%0d err=%0d required 13 0 0", id, resp, err);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic w; logic [5:0] id; logic [1:0] resp, err;
        int beat = 0, st_seen = 0;
        send_cmd(1'b1, 32'h4000_0000, 4'd3, 6'd9);
        wready = 1'b1;
        for (int cyc = 0; cyc < 40 && beat < 2; cyc++) begin
            awready = 1'b1; wr_valid = 1'b1; wr_data = 32'hA0 + beat;
            #1;
            if (wvalid && wready) beat++;
            @(negedge clk);
        end
        wr_data = 32'hA2;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wvalid !== 1'b0 || wr_ready !== 1'b0 || wlast !== 1'b0 || awvalid !== 1'b0 ||
            cmd_ready !== 1'b0 || bready !== 1'b0 || st_valid !== 1'b0 || st_id !== 6'd0) begin
            errors++;
            $display("FAIL reset_async: wvalid=%b wr_ready=%b awvalid=%b cmd_ready=%b st_valid=%b st_id=%0d required all 0",
                     wvalid, wr_ready, awvalid, cmd_ready, st_valid, st_id);
        end
        wr_valid = 1'b0; awready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (st_valid) st_seen++;
        end
        checks++;
        if (st_seen != 0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_recover: st_valid cycles=%0d cmd_ready=%b required 0 1", st_seen, cmd_ready);
        end
        write_burst(32'h4000_0010, 4'd3, 6'd10, 1, 2'b00, 6'd10);
        wait_status(w, id, resp, err);
        checks++;
        if (w !== 1'b1 || id !== 6'd10 || resp !== 2'b00 || err !== 2'b00) begin
            errors++; $display("FAIL post_reset_status: w=%b id=%0d resp=%0d err=%0d required 1 10 0 0", w, id, resp, err);
        end
    endtask

    task automatic test_width64();
        @(negedge clk);
        cmd_valid_b = 1'b1; cmd_addr_b = 32'h0000_0020; cmd_id_b = 6'd3;
        #1;
        checks++;
        if (cmd_ready_b !== 1'b1) begin
            errors++; $display("FAIL w64_cmd_ready: cmd_ready=%b required 1", cmd_ready_b);
        end
        @(negedge clk); cmd_valid_b = 1'b0;
        awready_b = 1'b1; #1;
        checks++;
        if (awvalid_b !== 1'b1 || awsize_b !== 3'd3 || awaddr_b !== 32'h20 || awlen_b !== 4'd0 || awid_b !== 6'd3) begin
            errors++;
            $display("FAIL w64_aw: awvalid=%b awsize=%0d awaddr=%h awlen=%0d required 1 3 00000020 0",
                     awvalid_b, awsize_b, awaddr_b, awlen_b);
        end
        @(negedge clk);
        awready_b = 1'b0; wr_valid_b = 1'b1; wready_b = 1'b1; wr_data_b = 64'h1122_3344_5566_7788;
        #1;
        checks++;
        if (wvalid_b !== 1'b1 || wlast_b !== 1'b1 || wstrb_b !== 8'hFF || wdata_b !== 64'h1122_3344_5566_7788) begin
            errors++;
            $display("FAIL w64_beat: wvalid=%b wlast=%b wstrb=%h wdata=%h required 1 1 ff 1122334455667788",
                     wvalid_b, wlast_b, wstrb_b, wdata_b);
        end
        @(negedge clk);
        wr_valid_b = 1'b0; bvalid_b = 1'b1; bid_b = 6'd3;
        #1;
        checks++;
        if (bready_b !== 1'b1) begin
            errors++; $display("FAIL w64_bready: bready=%b required 1", bready_b);
        end
        @(negedge clk);
        bvalid_b = 1'b0; st_ready_b = 1'b1;
        #1;
        checks++;
        if (st_valid_b !== 1'b1 || st_write_b !== 1'b1 || st_id_b !== 6'd3 || st_resp_b !== 2'b00 || st_err_b !== 2'b00) begin
            errors++;
            $display("FAIL w64_status: valid=%b write=%b id=%0d resp=%0d err=%0d required 1 1 3 0 0",
                     st_valid_b, st_write_b, st_id_b, st_resp_b, st_err_b);
        end
        @(negedge clk); st_ready_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        cfg_cache = 4'b0011; cfg_prot = 3'b000;
        wr_valid = 0; wr_data = 0; rd_ready = 0; st_ready = 0;
        arready = 0; awready = 0; wready = 0;
        bid = 0; bresp = 0; bvalid = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        cmd_valid_b = 0; cmd_addr_b = 0; cmd_id_b = 0;
        wr_valid_b = 0; wr_data_b = 0; st_ready_b = 0;
        awready_b = 0; wready_b = 0; bid_b = 0; bvalid_b = 0;

        test_reset();
        test_write_basic();
        test_write_bid_mismatch();
        test_read_len15();
        test_read_rlast_mismatch();
        test_4k();
        test_reset_mid_burst();
        test_width64();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
